// File: rtl/st7735_pkg.sv
`default_nettype none
// ============================================================================
// Module      : st7735_pkg
// Description : Shared definitions for the ST7735R SPI receive front-end:
//               command codes, decode-context states, default window ends.
// Revision    : 1.0 - initial release
// ============================================================================
package st7735_pkg;

    // ST7735R command codes recognised (or passed through) by the receiver
    localparam logic [7:0] CMD_NOP     = 8'h00;
    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_DISPOFF = 8'h28;
    localparam logic [7:0] CMD_DISPON  = 8'h29;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_RASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;

    // Reset / SWRESET window ends (480 x 272 panel)
    localparam int DEFAULT_COL_END = 479;
    localparam int DEFAULT_ROW_END = 271;

    // Data-byte index value meaning "all four address bytes consumed"
    localparam logic [2:0] IDX_ADDR_DONE = 3'd4;

    // Which command the following data bytes belong to
    typedef enum logic [1:0] {
        CTX_IDLE  = 2'd0,
        CTX_CASET = 2'd1,
        CTX_RASET = 2'd2,
        CTX_RAMWR = 2'd3
    } ctx_e;

endpackage
`default_nettype wire

// File: rtl/spi_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : spi_rx_sync
// Description : Brings SPI_CLK, SPI_CS, SPI_MOSI and DC into the mco domain
//               through SYNC_STAGES flip-flops each, and detects the SPI_CLK
//               rising edge and the CS rising edge on the synced samples.
// Ports       : i_clk, i_rst_n         mco clock, async active-low reset
//               i_spi_clk/cs/mosi,i_dc raw asynchronous SPI pins
//               o_mosi, o_dc, o_cs     synchronized levels
//               o_sclk_rise            1-cycle pulse on synced SPI_CLK 0->1
//               o_cs_rise              1-cycle pulse on synced CS 0->1
// Revision    : 1.0 - initial release
// ============================================================================
module spi_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_spi_clk,
    input  logic i_spi_cs,
    input  logic i_spi_mosi,
    input  logic i_dc,
    output logic o_mosi,
    output logic o_dc,
    output logic o_cs,
    output logic o_sclk_rise,
    output logic o_cs_rise
);

    // Lane order {dc, mosi, cs, sclk}; CS resets to 1 (deselected) so that
    // leaving reset never looks like a CS edge or an accepted SPI_CLK edge.
    localparam logic [3:0] RST_VAL = 4'b0010;

    logic [3:0] async_in;
    logic [3:0] synced;
    logic       sclk_prev_q;
    logic       cs_prev_q;

    assign async_in = {i_dc, i_spi_mosi, i_spi_cs, i_spi_clk};

    for (genvar l = 0; l < 4; l++) begin : g_lane
        logic [SYNC_STAGES-1:0] ff_q;
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                ff_q <= {SYNC_STAGES{RST_VAL[l]}};
            end else begin
                ff_q <= {ff_q[SYNC_STAGES-2:0], async_in[l]};
            end
        end
        assign synced[l] = ff_q[SYNC_STAGES-1];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_prev_q <= synced[0];
            cs_prev_q   <= synced[1];
        end
    end

    assign o_cs        = synced[1];
    assign o_mosi      = synced[2];
    assign o_dc        = synced[3];
    assign o_sclk_rise = synced[0] & ~sclk_prev_q;
    assign o_cs_rise   = synced[1] & ~cs_prev_q;

endmodule
`default_nettype wire

// File: rtl/st7735_spi_rx.sv
`default_nettype none
// ============================================================================
// Module      : st7735_spi_rx
// Description : SPI mode-0 slave emulating the ST7735R write path. Assembles
//               MSB-first bytes, decodes commands (DC=0) and their data bytes
//               (DC=1) into instruction, CASET/RASET window and RGB565 pixel
//               strobes, all synchronous to i_clk (mco).
// Ports       : i_clk, i_rst_n                     mco clock, async reset (low)
//               i_spi_clk, i_spi_cs, i_spi_mosi    SPI pins (async)
//               i_dc                               H data / L command
//               o_inst_data, o_inst_en_pls         last command byte + strobe
//               o_col_addr,  o_col_addr_en_pls     {XS,XE} + strobe
//               o_row_addr,  o_row_addr_en_pls     {YS,YE} + strobe
//               o_pixel_data, o_pixel_en_pls       RGB565 pixel + strobe
// Config      : ST7735_SPI_RX_PIXEL_SWAP_EN - when defined the first RAMWR
//               byte of each pixel is the low byte; otherwise big-endian.
// Revision    : 1.0 - initial release
// ============================================================================
module st7735_spi_rx
    import st7735_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEF_COL_END = DEFAULT_COL_END,
    parameter int DEF_ROW_END = DEFAULT_ROW_END
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_spi_clk,
    input  logic        i_spi_cs,
    input  logic        i_spi_mosi,
    input  logic        i_dc,
    output logic [7:0]  o_inst_data,
    output logic        o_inst_en_pls,
    output logic [31:0] o_col_addr,
    output logic        o_col_addr_en_pls,
    output logic [31:0] o_row_addr,
    output logic        o_row_addr_en_pls,
    output logic [15:0] o_pixel_data,
    output logic        o_pixel_en_pls
);

    localparam logic [31:0] COL_RST = {16'd0, 16'(DEF_COL_END)};
    localparam logic [31:0] ROW_RST = {16'd0, 16'(DEF_ROW_END)};

    // ---------------------------------------------------------------- sync
    logic mosi_s, dc_s, cs_s, sclk_rise, cs_rise, bit_edge;

    spi_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_spi_clk   (i_spi_clk),
        .i_spi_cs    (i_spi_cs),
        .i_spi_mosi  (i_spi_mosi),
        .i_dc        (i_dc),
        .o_mosi      (mosi_s),
        .o_dc        (dc_s),
        .o_cs        (cs_s),
        .o_sclk_rise (sclk_rise),
        .o_cs_rise   (cs_rise)
    );

    // SPI_CLK edges only count while the slave is selected
    assign bit_edge = sclk_rise & ~cs_s;

    // ------------------------------------------------------ byte assembly
    logic [2:0] bit_cnt_q;
    logic [6:0] shift_q;
    logic       dc_lat_q;
    logic [7:0] byte_q;
    logic       byte_dc_q;
    logic       byte_vld_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bit_cnt_q  <= 3'd0;
            shift_q    <= 7'd0;
            dc_lat_q   <= 1'b0;
            byte_q     <= 8'd0;
            byte_dc_q  <= 1'b0;
            byte_vld_q <= 1'b0;
        end else begin
            byte_vld_q <= 1'b0;
            if (cs_rise) begin
                // partial byte is thrown away; next byte starts at bit 7
                bit_cnt_q <= 3'd0;
            end else if (bit_edge) begin
                shift_q   <= {shift_q[5:0], mosi_s};
                bit_cnt_q <= bit_cnt_q + 3'd1;
                // DC is qualified with the MSB, the first bit of the byte
                if (bit_cnt_q == 3'd0) begin
                    dc_lat_q <= dc_s;
                end
                if (bit_cnt_q == 3'd7) begin
                    byte_q     <= {shift_q, mosi_s};
                    byte_dc_q  <= dc_lat_q;
                    byte_vld_q <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------- context / decode
    ctx_e        ctx_q, ctx_d;
    logic [2:0]  idx_q, idx_d;           // data-byte index; 4 = address complete
    logic [23:0] addr_buf_q, addr_buf_d; // first three address bytes
    logic [31:0] col_q, col_d;
    logic [31:0] row_q, row_d;
    logic [7:0]  pix_first_q, pix_first_d;
    logic [15:0] pix_q, pix_d;
    logic [7:0]  inst_q, inst_d;
    logic        inst_pls_q, inst_pls_d;
    logic        col_pls_q, col_pls_d;
    logic        row_pls_q, row_pls_d;
    logic        pix_pls_q, pix_pls_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ctx_q       <= CTX_IDLE;
            idx_q       <= 3'd0;
            addr_buf_q  <= 24'd0;
            col_q       <= COL_RST;
            row_q       <= ROW_RST;
            pix_first_q <= 8'd0;
            pix_q       <= 16'd0;
            inst_q      <= 8'd0;
            inst_pls_q  <= 1'b0;
            col_pls_q   <= 1'b0;
            row_pls_q   <= 1'b0;
            pix_pls_q   <= 1'b0;
        end else begin
            ctx_q       <= ctx_d;
            idx_q       <= idx_d;
            addr_buf_q  <= addr_buf_d;
            col_q       <= col_d;
            row_q       <= row_d;
            pix_first_q <= pix_first_d;
            pix_q       <= pix_d;
            inst_q      <= inst_d;
            inst_pls_q  <= inst_pls_d;
            col_pls_q   <= col_pls_d;
            row_pls_q   <= row_pls_d;
            pix_pls_q   <= pix_pls_d;
        end
    end

    always_comb begin
        ctx_d       = ctx_q;
        idx_d       = idx_q;
        addr_buf_d  = addr_buf_q;
        col_d       = col_q;
        row_d       = row_q;
        pix_first_d = pix_first_q;
        pix_d       = pix_q;
        inst_d      = inst_q;
        inst_pls_d  = 1'b0;
        col_pls_d   = 1'b0;
        row_pls_d   = 1'b0;
        pix_pls_d   = 1'b0;

        if (byte_vld_q) begin
            if (!byte_dc_q) begin
                // every command restarts data indexing, aborting partials
                inst_d     = byte_q;
                inst_pls_d = 1'b1;
                idx_d      = 3'd0;
                case (byte_q)
                    CMD_CASET: ctx_d = CTX_CASET;
                    CMD_RASET: ctx_d = CTX_RASET;
                    CMD_RAMWR: ctx_d = CTX_RAMWR;
                    CMD_SWRESET: begin
                        ctx_d = CTX_IDLE;
                        col_d = COL_RST;
                        row_d = ROW_RST;
                    end
                    default:   ctx_d = CTX_IDLE;
                endcase
            end else begin
                case (ctx_q)
                    CTX_CASET, CTX_RASET: begin
                        if (idx_q == 3'd3) begin
                            // whole window updates at once on the last byte
                            if (ctx_q == CTX_CASET) begin
                                col_d     = {addr_buf_q, byte_q};
                                col_pls_d = 1'b1;
                            end else begin
                                row_d     = {addr_buf_q, byte_q};
                                row_pls_d = 1'b1;
                            end
                            idx_d = IDX_ADDR_DONE;
                        end else if (idx_q != IDX_ADDR_DONE) begin
                            addr_buf_d = {addr_buf_q[15:0], byte_q};
                            idx_d      = idx_q + 3'd1;
                        end
                    end
                    CTX_RAMWR: begin
                        if (!idx_q[0]) begin
                            pix_first_d = byte_q;
                        end else begin
`ifdef ST7735_SPI_RX_PIXEL_SWAP_EN
                            pix_d = {byte_q, pix_first_q};
`else
                            pix_d = {pix_first_q, byte_q};
`endif
                            pix_pls_d = 1'b1;
                        end
                        idx_d = idx_q ^ 3'd1;
                    end
                    default: ;
                endcase
            end
        end

        if (cs_rise) begin
            idx_d = 3'd0;
        end
    end

    assign o_inst_data       = inst_q;
    assign o_inst_en_pls     = inst_pls_q;
    assign o_col_addr        = col_q;
    assign o_col_addr_en_pls = col_pls_q;
    assign o_row_addr        = row_q;
    assign o_row_addr_en_pls = row_pls_q;
    assign o_pixel_data      = pix_q;
    assign o_pixel_en_pls    = pix_pls_q;

endmodule
`default_nettype wire

// File: tb/tb_st7735_spi_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_st7735_spi_rx
// Description : Directed self-checking bench for st7735_spi_rx. SPI pins are
//               driven on falling i_clk edges, each SPI_CLK phase lasting four
//               i_clk periods; DUT strobes are logged on falling i_clk edges.
// Config      : honours ST7735_SPI_RX_PIXEL_SWAP_EN for pixel expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_st7735_spi_rx;

    localparam int SYNC = 2;
    localparam int TCLK = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_clk = 1'b0;
    logic        spi_cs = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        dc = 1'b0;
    logic [7:0]  o_inst_data;
    logic        o_inst_en_pls;
    logic [31:0] o_col_addr;
    logic        o_col_addr_en_pls;
    logic [31:0] o_row_addr;
    logic        o_row_addr_en_pls;
    logic [15:0] o_pixel_data;
    logic        o_pixel_en_pls;

    int n_assert = 0;
    int n_fail   = 0;

    // strobe logs, written only by the monitor
    int          inst_n = 0;
    int          col_n  = 0;
    int          row_n  = 0;
    logic [7:0]  last_inst = 8'h00;
    time         inst_t = 0;
    time         rise_t = 0;
    logic [15:0] pix_log[$];

    always #(TCLK/2) clk = ~clk;

    st7735_spi_rx #(
        .SYNC_STAGES(SYNC),
        .DEF_COL_END(479),
        .DEF_ROW_END(271)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_spi_clk         (spi_clk),
        .i_spi_cs          (spi_cs),
        .i_spi_mosi        (spi_mosi),
        .i_dc              (dc),
        .o_inst_data       (o_inst_data),
        .o_inst_en_pls     (o_inst_en_pls),
        .o_col_addr        (o_col_addr),
        .o_col_addr_en_pls (o_col_addr_en_pls),
        .o_row_addr        (o_row_addr),
        .o_row_addr_en_pls (o_row_addr_en_pls),
        .o_pixel_data      (o_pixel_data),
        .o_pixel_en_pls    (o_pixel_en_pls)
    );

    always @(negedge clk) begin
        if (o_inst_en_pls) begin
            inst_n++;
            last_inst = o_inst_data;
            inst_t    = $time;
        end
        if (o_col_addr_en_pls) col_n++;
        if (o_row_addr_en_pls) row_n++;
        if (o_pixel_en_pls) pix_log.push_back(o_pixel_data);
    end

    // ------------------------------------------------------------ drivers
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input logic d);
        @(negedge clk);
        spi_mosi = b;
        dc       = d;
        repeat (3) @(negedge clk);
        spi_clk = 1'b1;
        rise_t  = $time;
        repeat (4) @(negedge clk);
        spi_clk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v, input logic d);
        for (int i = 7; i >= 0; i--) send_bit(v[i], d);
    endtask

    task automatic cs_low();
        @(negedge clk);
        spi_cs = 1'b0;
        idle(4);
    endtask

    task automatic cs_bounce();
        @(negedge clk);
        spi_cs = 1'b1;
        idle(8);
        spi_cs = 1'b0;
        idle(4);
    endtask

    // -------------------------------------------------------------- tests
    task automatic test_reset();
        rst_n = 1'b0;
        idle(5);
        n_assert++;
        if ({o_inst_en_pls, o_col_addr_en_pls, o_row_addr_en_pls, o_pixel_en_pls} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b expected 0000",
                     {o_inst_en_pls, o_col_addr_en_pls, o_row_addr_en_pls, o_pixel_en_pls});
        end
        n_assert++;
        if (o_inst_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_inst: got %h expected 00", o_inst_data);
        end
        n_assert++;
        if (o_col_addr !== 32'h0000_01DF) begin
            n_fail++; $display("FAIL reset_col: got %h expected 000001df", o_col_addr);
        end
        n_assert++;
        if (o_row_addr !== 32'h0000_010F) begin
            n_fail++; $display("FAIL reset_row: got %h expected 0000010f", o_row_addr);
        end
        n_assert++;
        if (o_pixel_data !== 16'h0000) begin
            n_fail++; $display("FAIL reset_pixel: got %h expected 0000", o_pixel_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);
    endtask

    task automatic test_inst_latency();
        int  base;
        time lat;
        cs_low();
        base = inst_n;
        send_byte(8'h29, 1'b0);
        idle(10);
        n_assert++;
        if (inst_n - base !== 1) begin
            n_fail++; $display("FAIL inst_count: got %0d expected 1", inst_n - base);
        end
        n_assert++;
        if (last_inst !== 8'h29) begin
            n_fail++; $display("FAIL inst_data: got %h expected 29", last_inst);
        end
        lat = inst_t - rise_t;
        n_assert++;
        if (lat !== time'(TCLK * (SYNC + 2))) begin
            n_fail++; $display("FAIL inst_latency: got %0t expected %0d", lat, TCLK * (SYNC + 2));
        end
    endtask

    task automatic test_window();
        int cbase, rbase;
        cbase = col_n;
        send_byte(8'h2A, 1'b0);
        send_byte(8'h00, 1'b1); send_byte(8'h10, 1'b1);
        send_byte(8'h01, 1'b1); send_byte(8'h2F, 1'b1);
        idle(10);
        n_assert++;
        if (col_n - cbase !== 1) begin
            n_fail++; $display("FAIL caset_strobes: got %0d expected 1", col_n - cbase);
        end
        n_assert++;
        if (o_col_addr !== 32'h0010_012F) begin
            n_fail++; $display("FAIL caset_value: got %h expected 0010012f", o_col_addr);
        end
        // a fifth data byte must be ignored
        send_byte(8'hFF, 1'b1);
        idle(10);
        n_assert++;
        if (col_n - cbase !== 1 || o_col_addr !== 32'h0010_012F) begin
            n_fail++; $display("FAIL caset_extra: got %0d/%h expected 1/0010012f", col_n - cbase, o_col_addr);
        end
        rbase = row_n;
        send_byte(8'h2B, 1'b0);
        send_byte(8'h00, 1'b1); send_byte(8'h05, 1'b1);
        send_byte(8'h00, 1'b1); send_byte(8'h20, 1'b1);
        idle(10);
        n_assert++;
        if (row_n - rbase !== 1) begin
            n_fail++; $display("FAIL raset_strobes: got %0d expected 1", row_n - rbase);
        end
        n_assert++;
        if (o_row_addr !== 32'h0005_0020) begin
            n_fail++; $display("FAIL raset_value: got %h expected 00050020", o_row_addr);
        end
    endtask

    task automatic test_pixels();
        int          base;
        logic [15:0] exp0, exp1, exp2;
`ifdef ST7735_SPI_RX_PIXEL_SWAP_EN
        exp0 = 16'h00F8; exp1 = 16'hE007; exp2 = 16'h1F00;
`else
        exp0 = 16'hF800; exp1 = 16'h07E0; exp2 = 16'h001F;
`endif
        base = pix_log.size();
        send_byte(8'h2C, 1'b0);
        send_byte(8'hF8, 1'b1); send_byte(8'h00, 1'b1);
        send_byte(8'h07, 1'b1); send_byte(8'hE0, 1'b1);
        send_byte(8'h00, 1'b1); send_byte(8'h1F, 1'b1);
        idle(10);
        n_assert++;
        if (pix_log.size() - base !== 3) begin
            n_fail++; $display("FAIL pixel_count: got %0d expected 3", pix_log.size() - base);
        end
        if (pix_log.size() >= base + 3) begin
            n_assert++;
            if (pix_log[base] !== exp0) begin
                n_fail++; $display("FAIL pixel0: got %h expected %h", pix_log[base], exp0);
            end
            n_assert++;
            if (pix_log[base+1] !== exp1) begin
                n_fail++; $display("FAIL pixel1: got %h expected %h", pix_log[base+1], exp1);
            end
            n_assert++;
            if (pix_log[base+2] !== exp2) begin
                n_fail++; $display("FAIL pixel2: got %h expected %h", pix_log[base+2], exp2);
            end
        end
    endtask

    task automatic test_abort_swreset();
        int cbase, rbase, ibase;
        cbase = col_n;
        rbase = row_n;
        send_byte(8'h2A, 1'b0);
        send_byte(8'h00, 1'b1); send_byte(8'h01, 1'b1);
        send_byte(8'h2C, 1'b0);
        idle(10);
        n_assert++;
        if (col_n - cbase !== 0 || o_col_addr !== 32'h0010_012F) begin
            n_fail++; $display("FAIL abort_col: got %0d/%h expected 0/0010012f", col_n - cbase, o_col_addr);
        end
        ibase = inst_n;
        send_byte(8'h01, 1'b0);
        idle(10);
        n_assert++;
        if (o_col_addr !== 32'h0000_01DF) begin
            n_fail++; $display("FAIL swreset_col: got %h expected 000001df", o_col_addr);
        end
        n_assert++;
        if (o_row_addr !== 32'h0000_010F) begin
            n_fail++; $display("FAIL swreset_row: got %h expected 0000010f", o_row_addr);
        end
        n_assert++;
        if (col_n - cbase !== 0 || row_n - rbase !== 0) begin
            n_fail++; $display("FAIL swreset_strobes: got %0d/%0d expected 0/0", col_n - cbase, row_n - rbase);
        end
        n_assert++;
        if (inst_n - ibase !== 1 || last_inst !== 8'h01) begin
            n_fail++; $display("FAIL swreset_inst: got %0d/%h expected 1/01", inst_n - ibase, last_inst);
        end
    endtask

    task automatic test_cs_realign();
        int          base, ibase;
        logic [15:0] exp;
`ifdef ST7735_SPI_RX_PIXEL_SWAP_EN
        exp = 16'h3412;
`else
        exp = 16'h1234;
`endif
        send_byte(8'h2C, 1'b0);
        idle(6);
        base  = pix_log.size();
        ibase = inst_n;
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1);
        cs_bounce();
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        idle(10);
        n_assert++;
        if (pix_log.size() - base !== 1 || inst_n - ibase !== 0) begin
            n_fail++; $display("FAIL cs_realign_count: got %0d pix/%0d inst expected 1/0",
                               pix_log.size() - base, inst_n - ibase);
        end
        if (pix_log.size() > base) begin
            n_assert++;
            if (pix_log[base] !== exp) begin
                n_fail++; $display("FAIL cs_realign_pixel: got %h expected %h", pix_log[base], exp);
            end
        end
    endtask

    task automatic test_reset_midstream();
        int          base;
        logic [15:0] exp;
`ifdef ST7735_SPI_RX_PIXEL_SWAP_EN
        exp = 16'hCDAB;
`else
        exp = 16'hABCD;
`endif
        send_byte(8'h2C, 1'b0);
        send_byte(8'hAA, 1'b1);
        for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_assert++;
        if ({o_inst_en_pls, o_col_addr_en_pls, o_row_addr_en_pls, o_pixel_en_pls} !== 4'b0
            || o_col_addr !== 32'h0000_01DF || o_row_addr !== 32'h0000_010F) begin
            n_fail++; $display("FAIL midreset_state: got %b/%h/%h expected 0000/000001df/0000010f",
                {o_inst_en_pls, o_col_addr_en_pls, o_row_addr_en_pls, o_pixel_en_pls}, o_col_addr, o_row_addr);
        end
        n_assert++;
        if (o_pixel_data !== 16'h0000 || o_inst_data !== 8'h00) begin
            n_fail++; $display("FAIL midreset_data: got %h/%h expected 0000/00", o_pixel_data, o_inst_data);
        end
        idle(3);
        rst_n = 1'b1;
        idle(4);
        cs_bounce();
        base = pix_log.size();
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b1);
        idle(10);
        n_assert++;
        if (pix_log.size() - base !== 0) begin
            n_fail++; $display("FAIL idle_data_dropped: got %0d expected 0", pix_log.size() - base);
        end
        send_byte(8'h2C, 1'b0);
        send_byte(8'hAB, 1'b1);
        send_byte(8'hCD, 1'b1);
        idle(10);
        n_assert++;
        if (pix_log.size() - base !== 1) begin
            n_fail++; $display("FAIL recover_count: got %0d expected 1", pix_log.size() - base);
        end
        if (pix_log.size() > base) begin
            n_assert++;
            if (pix_log[base] !== exp) begin
                n_fail++; $display("FAIL recover_pixel: got %h expected %h", pix_log[base], exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_inst_latency();
        test_window();
        test_pixels();
        test_abort_swreset();
        test_cs_realign();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
